// File: rtl/conv_requant_act_if.sv
//----------------------------------------------------------------------------
// conv_requant_act_if
//
// Purpose : valid/ready stream bundle used for both the accumulator input
//           and the requantised output of conv_requant_act. One instance
//           carries one direction. W sets the data width.
//
// Signals :
//   valid  producer -> consumer  beat present on data
//   ready  consumer -> producer  beat taken when valid && ready
//   data   producer -> consumer  W-bit payload
//
// Modports:
//   master  producer side (drives valid/data, samples ready)
//   slave   consumer side (samples valid/data, drives ready)
//----------------------------------------------------------------------------
interface conv_requant_act_if #(
   parameter int W = 8
) ();

   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface : conv_requant_act_if

// File: rtl/conv_requant_act.sv
//----------------------------------------------------------------------------
// conv_requant_act
//
// Purpose : three-stage requantisation and activation pipeline for CH lanes
//           of signed ACC_W-bit convolution accumulators. Per lane:
//             S1  a = (x >>> pre_shift) - offset           (ACC_W+1 bits)
//             S2  b = (a + round_bias) >>> post_shift      (ACC_W+2 bits)
//             S3  clamp to signed OUT_W, then activation
//           A saturating counter tallies lanes that hit the clamp.
//
// Ports   :
//   clk, rst          clock; asynchronous active-high reset
//   in_beat (slave)   CH*ACC_W-bit accumulator beats, lane i at [i*ACC_W +: ACC_W]
//   out_beat (master) CH*OUT_W-bit results, lane i at [i*OUT_W +: OUT_W]
//   cfg_we            config write strobe, honoured only when idle
//   cfg_pre_shift     arithmetic right shift applied first
//   cfg_offset        signed offset subtracted after the pre-shift
//   cfg_post_shift    arithmetic right shift after the offset
//   cfg_round         add half an LSB before the post-shift
//   cfg_mode          0/3 clamp, 1 ReLU, 2 ReLU capped at cfg_cap
//   cfg_cap           unsigned upper bound for mode 2
//   sat_clr           clears sat_cnt and cfg_err
//   busy              some stage holds a valid beat
//   sat_cnt           saturating count of clamped lanes on delivered beats
//   cfg_err           sticky: a config write was dropped
//----------------------------------------------------------------------------
module conv_requant_act #(
   parameter int ACC_W   = 20,
   parameter int OUT_W   = 8,
   parameter int CH      = 4,
   parameter int SHIFT_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   conv_requant_act_if.slave        in_beat,
   conv_requant_act_if.master       out_beat,
   input  logic                     cfg_we,
   input  logic [SHIFT_W-1:0]       cfg_pre_shift,
   input  logic [ACC_W-1:0]         cfg_offset,
   input  logic [SHIFT_W-1:0]       cfg_post_shift,
   input  logic                     cfg_round,
   input  logic [1:0]               cfg_mode,
   input  logic [OUT_W-2:0]         cfg_cap,
   input  logic                     sat_clr,
   output logic                     busy,
   output logic [CNT_W-1:0]         sat_cnt,
   output logic                     cfg_err
);

   localparam int A1_W = ACC_W + 1;        // after offset subtract
   localparam int A2_W = ACC_W + 2;        // after rounding bias
   localparam int SN_W = $clog2(CH + 1);   // saturated lanes per beat

   // Clamp limits held at stage-2 width so comparisons stay signed.
   localparam logic signed [A2_W-1:0] SAT_HI = A2_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [A2_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {
      MODE_CLAMP     = 2'd0,
      MODE_RELU      = 2'd1,
      MODE_RELU_CAP  = 2'd2,
      MODE_CLAMP_ALT = 2'd3
   } act_mode_e;

   //-------------------------------------------------------------------------
   // Configuration
   //-------------------------------------------------------------------------
   logic [SHIFT_W-1:0] pre_shift_q;
   logic [ACC_W-1:0]   offset_q;
   logic [SHIFT_W-1:0] post_shift_q;
   logic               round_q;
   act_mode_e          mode_q;
   logic [OUT_W-2:0]   cap_q;

   logic               cfg_ok;

   // Writes are only safe with nothing in flight and nothing being offered,
   // so later stages may read the live registers without per-beat copies.
   assign cfg_ok = cfg_we && !busy && !in_beat.valid;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_shift_q  <= SHIFT_W'(2);
         offset_q     <= ACC_W'(128);
         post_shift_q <= SHIFT_W'(5);
         round_q      <= 1'b0;
         mode_q       <= MODE_RELU;
         cap_q        <= '1;
      end else if (cfg_ok) begin
         pre_shift_q  <= cfg_pre_shift;
         offset_q     <= cfg_offset;
         post_shift_q <= cfg_post_shift;
         round_q      <= cfg_round;
         mode_q       <= act_mode_e'(cfg_mode);
         cap_q        <= cfg_cap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else if (sat_clr) begin
         cfg_err <= 1'b0;
      end else if (cfg_we && !cfg_ok) begin
         cfg_err <= 1'b1;
      end
   end

   //-------------------------------------------------------------------------
   // Pipeline control: one global enable, bubbles keep their slots
   //-------------------------------------------------------------------------
   logic en;
   logic v1_q, v2_q, v3_q;

   assign en            = !out_beat.valid || out_beat.ready;
   assign in_beat.ready = en;
   assign out_beat.valid = v3_q;
   assign busy          = v1_q || v2_q || v3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (en) begin
         v1_q <= in_beat.valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   //-------------------------------------------------------------------------
   // S1: pre-shift and offset subtract
   //-------------------------------------------------------------------------
   logic signed [A1_W-1:0] s1_a_d [CH];
   logic signed [A1_W-1:0] s1_a_q [CH];
   logic signed [A1_W-1:0] offset_ext;

   assign offset_ext = $signed({offset_q[ACC_W-1], offset_q});

   // NOTE: combinational blocks use blocking assignments and give every
   // output a value on every path, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         s1_a_d[i] = '0;
      end
      for (int i = 0; i < CH; i++) begin
         // >>> on a signed operand sign-fills even for shifts past its width.
         s1_a_d[i] = ($signed({in_beat.data[i*ACC_W + ACC_W - 1],
                               in_beat.data[i*ACC_W +: ACC_W]}) >>> pre_shift_q)
                     - offset_ext;
      end
   end

   // NOTE: pure datapath registers carry no reset; their contents are
   // qualified by the valid bits, which are reset.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_a_q <= s1_a_d;
      end
   end

   //-------------------------------------------------------------------------
   // S2: optional round-half-up bias and post-shift
   //-------------------------------------------------------------------------
   logic [A2_W-1:0]        rnd_add;
   logic signed [A2_W-1:0] s2_b_d [CH];
   logic signed [A2_W-1:0] s2_b_q [CH];

   always_comb begin
      rnd_add = '0;
      if (round_q && (post_shift_q != '0)) begin
         rnd_add = A2_W'(1) << (post_shift_q - 1'b1);
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         s2_b_d[i] = '0;
      end
      for (int i = 0; i < CH; i++) begin
         s2_b_d[i] = ($signed({s1_a_q[i][A1_W-1], s1_a_q[i]}) + $signed(rnd_add))
                     >>> post_shift_q;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s2_b_q <= s2_b_d;
      end
   end

   //-------------------------------------------------------------------------
   // S3: clamp, saturation flags, activation
   //-------------------------------------------------------------------------
   logic signed [OUT_W-1:0] lane_c   [CH];
   logic signed [OUT_W-1:0] lane_y   [CH];
   logic                    lane_sat [CH];
   logic signed [OUT_W-1:0] cap_ext;
   logic [CH*OUT_W-1:0]     out_d;
   logic [SN_W-1:0]         sat_n_d;

   logic [CH*OUT_W-1:0]     out_data_q;
   logic [SN_W-1:0]         sat_n_q;

   assign cap_ext = $signed({1'b0, cap_q});

   always_comb begin
      out_d   = '0;
      sat_n_d = '0;
      for (int i = 0; i < CH; i++) begin
         lane_c[i]   = '0;
         lane_y[i]   = '0;
         lane_sat[i] = 1'b0;
      end
      for (int i = 0; i < CH; i++) begin
         if (s2_b_q[i] > SAT_HI) begin
            lane_c[i]   = SAT_HI[OUT_W-1:0];
            lane_sat[i] = 1'b1;
         end else if (s2_b_q[i] < SAT_LO) begin
            lane_c[i]   = SAT_LO[OUT_W-1:0];
            lane_sat[i] = 1'b1;
         end else begin
            lane_c[i]   = s2_b_q[i][OUT_W-1:0];
         end

         // Activation limits are not saturation events; lane_sat is final.
         unique case (mode_q)
            MODE_RELU: begin
               lane_y[i] = (lane_c[i] < 0) ? '0 : lane_c[i];
            end
            MODE_RELU_CAP: begin
               if (lane_c[i] < 0) begin
                  lane_y[i] = '0;
               end else if (lane_c[i] > cap_ext) begin
                  lane_y[i] = cap_ext;
               end else begin
                  lane_y[i] = lane_c[i];
               end
            end
            MODE_CLAMP, MODE_CLAMP_ALT: begin
               lane_y[i] = lane_c[i];
            end
         endcase

         out_d[i*OUT_W +: OUT_W] = lane_y[i];
         sat_n_d = sat_n_d + SN_W'(lane_sat[i]);
      end
   end

   // Output stage is reset so out_data reads zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q <= '0;
         sat_n_q    <= '0;
      end else if (en) begin
         out_data_q <= out_d;
         sat_n_q    <= sat_n_d;
      end
   end

   assign out_beat.data = out_data_q;

   //-------------------------------------------------------------------------
   // Saturation event counter (sticks at all-ones, clear wins)
   //-------------------------------------------------------------------------
   logic             fire;
   logic [CNT_W:0]   sat_sum;

   assign fire    = out_beat.valid && out_beat.ready;
   assign sat_sum = {1'b0, sat_cnt} + (CNT_W + 1)'(sat_n_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (fire) begin
         sat_cnt <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
      end
   end

endmodule : conv_requant_act

// File: tb/tb_conv_requant_act.sv
//----------------------------------------------------------------------------
// tb_conv_requant_act
//
// Self-checking bench for conv_requant_act. A behavioural model computes
// each lane with plain integer arithmetic (floor division for the shifts)
// and queues expected beats at acceptance; a monitor compares delivered
// beats, stall behaviour and the saturation counter.
//----------------------------------------------------------------------------
module tb_conv_requant_act;

   localparam int ACC_W   = 20;
   localparam int OUT_W   = 8;
   localparam int CH      = 4;
   localparam int SHIFT_W = 5;
   localparam int CNT_W   = 16;

   typedef struct {
      int     pre;
      longint off;
      int     post;
      bit     rnd;
      int     mode;
      int     cap;
   } cfg_t;

   typedef struct {
      logic [CH*OUT_W-1:0] data;
      int                  nsat;
   } exp_t;

   localparam cfg_t CFG_DEFAULT = '{pre: 2, off: 128, post: 5, rnd: 1'b0, mode: 1, cap: 127};

   logic                 clk;
   logic                 rst;
   logic                 cfg_we;
   logic [SHIFT_W-1:0]   cfg_pre_shift;
   logic [ACC_W-1:0]     cfg_offset;
   logic [SHIFT_W-1:0]   cfg_post_shift;
   logic                 cfg_round;
   logic [1:0]           cfg_mode;
   logic [OUT_W-2:0]     cfg_cap;
   logic                 sat_clr;
   logic                 busy;
   logic [CNT_W-1:0]     sat_cnt;
   logic                 cfg_err;

   conv_requant_act_if #(.W(CH*ACC_W)) in_if ();
   conv_requant_act_if #(.W(CH*OUT_W)) out_if ();

   conv_requant_act #(
      .ACC_W(ACC_W), .OUT_W(OUT_W), .CH(CH), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_beat        (in_if),
      .out_beat       (out_if),
      .cfg_we         (cfg_we),
      .cfg_pre_shift  (cfg_pre_shift),
      .cfg_offset     (cfg_offset),
      .cfg_post_shift (cfg_post_shift),
      .cfg_round      (cfg_round),
      .cfg_mode       (cfg_mode),
      .cfg_cap        (cfg_cap),
      .sat_clr        (sat_clr),
      .busy           (busy),
      .sat_cnt        (sat_cnt),
      .cfg_err        (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t exp_q[$];
   cfg_t mcfg     = CFG_DEFAULT;
   int   delivered = 0;
   int   rdy_mode  = 0;   // 0 always, 1 toggle, 2 random, 3 held low

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   //-------------------------------------------------------------------------
   // Reference model
   //-------------------------------------------------------------------------
   function automatic longint floor_shift(input longint v, input int s);
      longint d;
      d = longint'(1) << s;
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic exp_t model_beat(input logic [CH*ACC_W-1:0] din, input cfg_t c);
      exp_t                    e;
      logic signed [ACC_W-1:0] lane;
      longint                  x, a, r, b, y, hi, lo;
      logic [63:0]             yb;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -hi - 1;
      e.data = '0;
      e.nsat = 0;
      for (int i = 0; i < CH; i++) begin
         lane = din[i*ACC_W +: ACC_W];
         x = lane;
         a = floor_shift(x, c.pre) - c.off;
         r = a + ((c.rnd && c.post > 0) ? (longint'(1) << (c.post - 1)) : longint'(0));
         b = floor_shift(r, c.post);
         y = (b > hi) ? hi : ((b < lo) ? lo : b);
         if (y != b) e.nsat++;
         if ((c.mode == 1 || c.mode == 2) && y < 0) y = 0;
         if (c.mode == 2 && y > c.cap) y = c.cap;
         yb = y;
         e.data[i*OUT_W +: OUT_W] = yb[OUT_W-1:0];
      end
      return e;
   endfunction

   function automatic logic [CH*ACC_W-1:0] all_lanes(input logic [ACC_W-1:0] v);
      logic [CH*ACC_W-1:0] d;
      for (int i = 0; i < CH; i++) d[i*ACC_W +: ACC_W] = v;
      return d;
   endfunction

   function automatic logic [CH*OUT_W-1:0] all_out(input logic [OUT_W-1:0] v);
      logic [CH*OUT_W-1:0] d;
      for (int i = 0; i < CH; i++) d[i*OUT_W +: OUT_W] = v;
      return d;
   endfunction

   function automatic logic [CH*ACC_W-1:0] rand_beat();
      logic [CH*ACC_W-1:0] d;
      for (int i = 0; i < CH; i++) begin
         case ($urandom_range(0, 3))
            0:       d[i*ACC_W +: ACC_W] = ACC_W'($urandom);
            1:       d[i*ACC_W +: ACC_W] = ACC_W'(20'h7FFFF);
            2:       d[i*ACC_W +: ACC_W] = ACC_W'(20'h80000);
            default: d[i*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 8000)) - 4000);
         endcase
      end
      return d;
   endfunction

   //-------------------------------------------------------------------------
   // Downstream ready pattern
   //-------------------------------------------------------------------------
   initial begin
      out_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_if.ready = 1'b1;
            1:       out_if.ready = ~out_if.ready;
            2:       out_if.ready = 1'($urandom_range(0, 1));
            default: out_if.ready = 1'b0;
         endcase
      end
   end

   //-------------------------------------------------------------------------
   // Monitor: sampled on the falling edge, acts on the next rising edge
   //-------------------------------------------------------------------------
   longint              m_sat = 0;
   bit                  held_v = 1'b0;
   logic [CH*OUT_W-1:0] held_data;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         m_sat  = 0;
         held_v = 1'b0;
      end else begin
         check("in_ready", in_if.ready, !(out_if.valid && !out_if.ready));
         check("sat_cnt", sat_cnt, m_sat);
         if (held_v) begin
            check("hold_valid", out_if.valid, 1'b1);
            check("hold_data", out_if.data, held_data);
         end
         held_v    = out_if.valid && !out_if.ready;
         held_data = out_if.data;
         e.nsat = 0;
         if (out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_if.data, e.data);
               delivered++;
            end
         end
         if (sat_clr) m_sat = 0;
         else if (out_if.valid && out_if.ready) begin
            m_sat = m_sat + e.nsat;
            if (m_sat > (longint'(1) << CNT_W) - 1) m_sat = (longint'(1) << CNT_W) - 1;
         end
      end
   end

   //-------------------------------------------------------------------------
   // Driver tasks (inputs change 1 unit after the rising edge)
   //-------------------------------------------------------------------------
   task automatic send(input logic [CH*ACC_W-1:0] d, input bit clr = 1'b0);
      bit acc = 1'b0;
      in_if.valid = 1'b1;
      in_if.data  = d;
      sat_clr     = clr;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         if (in_if.ready) begin
            exp_q.push_back(model_beat(d, mcfg));
            acc = 1'b1;
         end
         @(posedge clk);
         #1;
         sat_clr = 1'b0;
      end
      if (!acc) check("send_timeout", 1'b0, 1'b1);
      in_if.valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int k = 0; k < 1000 && !idle; k++) begin
         @(negedge clk);
         idle = !busy && (exp_q.size() == 0);
      end
      if (!idle) check("idle_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg_raw(input cfg_t c);
      logic [63:0] off_b;
      off_b          = c.off;
      cfg_we         = 1'b1;
      cfg_pre_shift  = SHIFT_W'(c.pre);
      cfg_offset     = off_b[ACC_W-1:0];
      cfg_post_shift = SHIFT_W'(c.post);
      cfg_round      = c.rnd;
      cfg_mode       = 2'(c.mode);
      cfg_cap        = (OUT_W-1)'(c.cap);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic write_cfg(input cfg_t c);
      wait_idle();
      write_cfg_raw(c);
      mcfg = c;
   endtask

   task automatic pulse_clr();
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
   endtask

   // Single beat with ready held high; checks latency and the literal result.
   task automatic send_expect(input string tag, input logic [CH*ACC_W-1:0] d,
                              input logic [CH*OUT_W-1:0] want);
      int lat = 1;
      send(d);
      while (!out_if.valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, lat, 3);
      check(tag, out_if.data, want);
      wait_idle();
   endtask

   //-------------------------------------------------------------------------
   // Stimulus
   //-------------------------------------------------------------------------
   initial begin
      cfg_t c;
      int   d0;
      rst = 1'b1;
      in_if.valid = 1'b0;
      in_if.data  = '0;
      cfg_we = 1'b0;
      cfg_pre_shift = '0; cfg_offset = '0; cfg_post_shift = '0;
      cfg_round = 1'b0; cfg_mode = '0; cfg_cap = '0;
      sat_clr = 1'b0;

      #2;
      check("rst_out_valid", out_if.valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sat_cnt", sat_cnt, '0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_out_data", out_if.data, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Default configuration, ReLU
      send_expect("dflt_1000", all_lanes(20'd1000), all_out(8'h03));
      send_expect("dflt_m4000", all_lanes(-20'sd4000), all_out(8'h00));

      // Saturation at both rails
      pulse_clr();
      send_expect("sat_hi", all_lanes(20'h7FFFF), all_out(8'h7F));
      check("sat_cnt_hi", sat_cnt, 16'd4);
      c = CFG_DEFAULT; c.mode = 0;
      write_cfg(c);
      send_expect("clamp_m4000", all_lanes(-20'sd4000), all_out(8'hDC));
      send_expect("sat_lo", all_lanes(20'h80000), all_out(8'h80));
      check("sat_cnt_lo", sat_cnt, 16'd8);

      // Rounding, then capped ReLU
      c = CFG_DEFAULT; c.rnd = 1'b1;
      write_cfg(c);
      send_expect("round_1000", all_lanes(20'd1000), all_out(8'h04));
      c.mode = 2; c.cap = 6;
      write_cfg(c);
      send_expect("cap_2000", all_lanes(20'd2000), all_out(8'h06));
      check("cap_no_sat", sat_cnt, 16'd8);

      // Stream under alternating backpressure
      d0 = delivered;
      rdy_mode = 1;
      for (int i = 0; i < 10; i++) send(rand_beat());
      wait_idle();
      check("stream_count", delivered - d0, 10);
      rdy_mode = 0;

      // Config write while busy is dropped and flagged
      send(all_lanes(20'd5));
      begin
         cfg_t bad;
         bad = CFG_DEFAULT; bad.mode = 0; bad.pre = 0;
         write_cfg_raw(bad);
      end
      check("cfg_err_set", cfg_err, 1'b1);
      wait_idle();
      send_expect("cfg_kept", all_lanes(20'd1000), all_out(8'h04));
      pulse_clr();
      check("cfg_err_clr", cfg_err, 1'b0);
      check("sat_cnt_clr", sat_cnt, '0);

      // Asynchronous reset with three beats in flight
      rdy_mode = 3;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(all_lanes(20'd1000));
      check("pre_rst_busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid", out_if.valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      mcfg = CFG_DEFAULT;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send_expect("post_rst_1000", all_lanes(20'd1000), all_out(8'h03));

      // Randomised configurations and traffic
      for (int r = 0; r < 8; r++) begin
         logic [ACC_W-1:0] off_r;
         c.pre  = $urandom_range(0, 31);
         off_r  = ACC_W'($urandom);
         c.off  = longint'($signed(off_r));
         c.rnd  = 1'($urandom_range(0, 1));
         c.post = $urandom_range(0, 21);
         if (!c.rnd && $urandom_range(0, 3) == 0) c.post = 31;
         c.mode = $urandom_range(0, 3);
         c.cap  = $urandom_range(0, 127);
         write_cfg(c);
         rdy_mode = $urandom_range(0, 2);
         for (int i = 0; i < 25; i++) send(rand_beat(), ($urandom_range(0, 15) == 0));
         wait_idle();
         rdy_mode = 0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

endmodule : tb_conv_requant_act

// File: doc/conv_requant_act.md
# conv_requant_act

Parametrised, pipelined requantisation and activation unit for convolution accumulator outputs inside the NICE coprocessor. Accepts CH lanes of signed ACC_W-bit accumulators per beat over a valid/ready stream. Per beat it applies a runtime-programmable pre-shift, offset subtract, optionally rounded post-shift, signed saturation and a selectable activation. Results are OUT_W-bit values per lane, plus a saturation event counter for quantisation tuning.

## Interface
- ACC_W, 20, accumulator width per lane (signed)
- OUT_W, 8, output width per lane
- CH, 4, lanes per beat
- SHIFT_W, 5, width of shift-amount fields
- CNT_W, 16, saturation counter width
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous and active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CH*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  CH*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
- cfg_we  in  1  config write strobe
- cfg_pre_shift  in  SHIFT_W  arithmetic right shift before offset
- cfg_offset  in  ACC_W  signed value subtracted after pre-shift
- cfg_post_shift  in  SHIFT_W  arithmetic right shift after offset
- cfg_round  in  1  round-half-up before post-shift
- cfg_mode  in  2  0 signed clamp, 1 ReLU, 2 ReLU with cap, 3 same as 0
- cfg_cap  in  OUT_W-1  unsigned cap for mode 2
- sat_clr  in  1  clears sat_cnt and cfg_err
- busy  out  1  any pipeline stage holds a valid beat
- sat_cnt  out  CNT_W  saturating count of lane saturation events
- cfg_err  out  1  sticky: cfg_we arrived while busy

## Operation
- Config registers reset to pre_shift 2, offset 128, post_shift 5, round 0, mode 1, cap 127.
- cfg_we is accepted only when busy=0 and in_valid=0. Otherwise the write is dropped and cfg_err is set.
- An accepted write takes effect for beats accepted from the next cycle on.
- Per lane, x = signed din:
  - a = (x >>> pre_shift) - offset, computed at ACC_W+1 bits.
  - r = a + (round && post_shift>0 ? 1<<(post_shift-1) : 0), computed at ACC_W+2 bits.
  - b = r >>> post_shift.
  - Shifts at or beyond the operand width yield sign fill.
- Clamp: c = b limited to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A lane is saturated when c != b.
- Activation:
  - mode 0/3: out = c.
  - mode 1: out = max(c,0).
  - mode 2: out = min(max(c,0),cap).
  - Zeroing or capping by the activation is not a saturation event.
- sat_cnt adds the number of saturated lanes in each beat leaving stage 3 with out_valid && out_ready. It sticks at all-ones. sat_clr has priority and zeroes it the same cycle.

## Timing
- Three register stages:
  - S1: pre-shift and offset.
  - S2: round and post-shift.
  - S3: clamp and activation, driving out_data and out_valid.
- Latency is 3 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Global stall: en = !out_valid || out_ready; in_ready = en. When en=0, all stages hold and bubbles do not collapse.
- out_data is stable while out_valid && !out_ready.
- busy = OR of S1/S2/S3 valid bits.
- Reset (asynchronous, any time including mid-stream): all valid bits 0, out_data 0, sat_cnt 0, cfg_err 0, config to defaults. In-flight beats are discarded.
- sat_clr coinciding with a counted beat: the result is 0.

## Test plan
- Defaults, mode 1, lane din=1000 -> out 3 after exactly 3 cycles. Lane din=-4000 -> out 0. With mode 0 written, din=-4000 -> 0xDC (-36).
- din=0x7FFFF on all 4 lanes, default config -> each lane 127, sat_cnt=4. din=0x80000 in mode 0 -> 0x80, sat_cnt +1 per lane.
- cfg_round=1, din=1000 -> 4 (122+16 >>> 5). Mode 2, cap=6, din=2000 -> 6, and sat_cnt unchanged.
- Stream 10 beats with out_ready toggling every other cycle -> all 10 beats delivered in order with no loss or duplication, out_data held while stalled, in_ready low exactly when out_valid && !out_ready.
- cfg_we while busy=1 -> config unchanged, cfg_err=1. sat_clr -> cfg_err=0 and sat_cnt=0.
- Assert rst with 3 beats in flight -> out_valid and busy drop to 0 immediately. Config returns to defaults and next beat din=1000 -> 3.
